// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and state encoding for the instruction fetcher
package if_pkg;

    localparam int IF_XLEN = 32;
    localparam logic [IF_XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DROP  = 3'd4
    } if_state_t;

    function automatic logic [IF_XLEN-1:0] word_align(input logic [IF_XLEN-1:0] addr);
        return {addr[IF_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - icache, decoder and redirect signals seen by the fetcher
interface inst_fetcher_if #(
    parameter int XLEN = 32
);
    logic            ic_req_valid;
    logic [XLEN-1:0] ic_req_addr;
    logic            ic_req_ready;
    logic            ic_rsp_valid;
    logic [XLEN-1:0] ic_rsp_data;
    logic [XLEN-1:0] dec_inst;
    logic            dec_inst_valid;
    logic [XLEN-1:0] dec_inst_addr;
    logic            dec_clear;
    logic            dec_stall;
    logic [XLEN-1:0] dec_next_pc;
    logic            be_full;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output ic_req_valid, ic_req_addr, dec_inst, dec_inst_valid, dec_inst_addr, dec_clear,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data, dec_stall, dec_next_pc, be_full,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  ic_req_valid, ic_req_addr, dec_inst, dec_inst_valid, dec_inst_addr, dec_clear,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data, dec_stall, dec_next_pc, be_full,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/if_perf_cnt.sv
// rtl/if_perf_cnt.sv - issue and stall cycle counters (built only with IF_PERF_CNT_EN)
module if_perf_cnt (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else if (rdy_in) begin
            if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_inc) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - PC holder and single-outstanding fetch FSM feeding the decoder; IF_PERF_CNT_EN adds perf counters
module inst_fetcher
    import if_pkg::*;
#(
    parameter int                 XLEN     = IF_XLEN,
    parameter logic [XLEN-1:0]    RESET_PC = RESET_PC_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    inst_fetcher_if.master    bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    if_state_t       state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] inst_reg, inst_nxt;
    logic            req_valid;
    logic            req_fire;
    logic            issue_fire;

    assign req_fire   = req_valid && bus.ic_req_ready;
    assign issue_fire = (state == ST_ISSUE) && !bus.be_full;

    // Request valid is registered so it reads 0 in reset and holds while rdy_in is low
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            inst_reg  <= '0;
            req_valid <= 1'b0;
        end else if (rdy_in) begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            inst_reg  <= inst_nxt;
            req_valid <= (state_nxt == ST_FETCH);
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst_reg;
        if (bus.redirect_valid) begin
            pc_nxt = word_align(bus.redirect_pc);
            // Any request still in flight after the redirect must have its response swallowed
            case (state)
                ST_FETCH: state_nxt = req_fire ? ST_DROP : ST_FETCH;
                ST_WAIT,
                ST_DROP:  state_nxt = bus.ic_rsp_valid ? ST_FETCH : ST_DROP;
                default:  state_nxt = ST_FETCH;
            endcase
        end else begin
            case (state)
                ST_FETCH: if (req_fire) state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (bus.ic_rsp_valid) begin
                        inst_nxt  = bus.ic_rsp_data;
                        state_nxt = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire) begin
                        if (bus.dec_stall) begin
                            state_nxt = ST_HOLD;
                        end else begin
                            pc_nxt    = word_align(bus.dec_next_pc);
                            state_nxt = ST_FETCH;
                        end
                    end
                end
                ST_DROP:  if (bus.ic_rsp_valid) state_nxt = ST_FETCH;
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        bus.ic_req_valid   = req_valid;
        bus.ic_req_addr    = pc;
        bus.dec_inst       = (state == ST_ISSUE) ? inst_reg : '0;
        bus.dec_inst_addr  = (state == ST_ISSUE) ? pc : '0;
        bus.dec_inst_valid = rdy_in && issue_fire && !bus.redirect_valid;
        bus.dec_clear      = bus.redirect_valid;
    end

`ifdef IF_PERF_CNT_EN
    if_perf_cnt u_perf_cnt (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .fetch_inc      (bus.dec_inst_valid),
        .stall_inc      ((state == ST_HOLD) || ((state == ST_ISSUE) && bus.be_full)),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed self-checking bench for inst_fetcher
module tb_inst_fetcher;
    logic clk;
    logic rst_n;
    logic rdy_in;
    int   n_pass;
    int   n_total;
    logic auto_ic;
    logic [31:0] ic_word;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    inst_fetcher_if #(.XLEN(32)) bus ();

    inst_fetcher #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // One clock; the automatic icache answers one cycle after an accepted request
    task automatic tick();
        logic acc;
        acc = auto_ic && bus.ic_req_valid && bus.ic_req_ready && rdy_in;
        @(posedge clk);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        if (auto_ic) begin
            bus.ic_rsp_valid = acc;
            bus.ic_rsp_data  = ic_word;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy_in = 1'b1;
        auto_ic = 1'b0;
        ic_word = 32'h0;
        bus.ic_req_ready = 1'b0;
        bus.ic_rsp_valid = 1'b0;
        bus.ic_rsp_data = 32'h0;
        bus.dec_stall = 1'b0;
        bus.dec_next_pc = 32'h0;
        bus.be_full = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (bus.ic_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", bus.ic_req_valid);
        else n_pass++;
        n_total++;
        if (bus.ic_req_addr !== 32'h0) $display("FAIL reset_req_addr got %h want 00000000", bus.ic_req_addr);
        else n_pass++;
        n_total++;
        if ({bus.dec_inst_valid, bus.dec_clear} !== 2'b00)
            $display("FAIL reset_dec_flags got %b want 00", {bus.dec_inst_valid, bus.dec_clear});
        else n_pass++;
        n_total++;
        if ({bus.dec_inst, bus.dec_inst_addr} !== 64'h0)
            $display("FAIL reset_dec_data got %h want 0", {bus.dec_inst, bus.dec_inst_addr});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fetch_seq();
        logic [31:0] a;
        auto_ic = 1'b1;
        ic_word = 32'h0000_0013;
        bus.ic_req_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            a = 32'(k * 4);
            n_total++;
            if ({bus.ic_req_valid, bus.ic_req_addr} !== {1'b1, a})
                $display("FAIL seq_req%0d got %b/%h want 1/%h", k, bus.ic_req_valid, bus.ic_req_addr, a);
            else n_pass++;
            bus.dec_next_pc = (k == 2) ? 32'h0000_0100 : a + 32'd4;
            tick();
            tick();
            n_total++;
            if ({bus.dec_inst_valid, bus.dec_inst_addr, bus.dec_inst} !== {1'b1, a, 32'h0000_0013})
                $display("FAIL seq_issue%0d got %b/%h/%h want 1/%h/00000013", k,
                         bus.dec_inst_valid, bus.dec_inst_addr, bus.dec_inst, a);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({bus.ic_req_valid, bus.ic_req_addr} !== {1'b1, 32'h0000_0100})
            $display("FAIL jal_target got %b/%h want 1/00000100", bus.ic_req_valid, bus.ic_req_addr);
        else n_pass++;
    endtask

    task automatic test_stall_hold();
        int bad;
        bus.dec_next_pc = 32'h0000_0012;
        tick();
        tick();
        tick();
        n_total++;
        if ({bus.ic_req_valid, bus.ic_req_addr} !== {1'b1, 32'h0000_0010})
            $display("FAIL next_pc_align got %b/%h want 1/00000010", bus.ic_req_valid, bus.ic_req_addr);
        else n_pass++;
        tick();
        tick();
        bus.dec_stall = 1'b1;
        #1;
        n_total++;
        if ({bus.dec_inst_valid, bus.dec_inst_addr} !== {1'b1, 32'h0000_0010})
            $display("FAIL stall_issue got %b/%h want 1/00000010", bus.dec_inst_valid, bus.dec_inst_addr);
        else n_pass++;
        tick();
        bus.dec_stall = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ic_req_valid || bus.dec_inst_valid) bad++;
            tick();
        end
        n_total++;
        if (bad !== 0) $display("FAIL hold_quiet got %0d active cycles want 0", bad);
        else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        #1;
        n_total++;
        if ({bus.dec_clear, bus.dec_inst_valid} !== 2'b10)
            $display("FAIL hold_redirect_clear got %b want 10", {bus.dec_clear, bus.dec_inst_valid});
        else n_pass++;
        tick();
        n_total++;
        if ({bus.ic_req_valid, bus.ic_req_addr, bus.dec_clear} !== {1'b1, 32'h0000_0200, 1'b0})
            $display("FAIL hold_redirect_req got %b/%h/%b want 1/00000200/0",
                     bus.ic_req_valid, bus.ic_req_addr, bus.dec_clear);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        auto_ic = 1'b0;
        tick();
        n_total++;
        if (bus.ic_req_valid !== 1'b0) $display("FAIL wait_no_req got %b want 0", bus.ic_req_valid);
        else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        #1;
        tick();
        tick();
        n_total++;
        if (bus.ic_req_valid !== 1'b0) $display("FAIL drop_no_req got %b want 0", bus.ic_req_valid);
        else n_pass++;
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data = 32'hDEAD_BEEF;
        #1;
        n_total++;
        if (bus.dec_inst_valid !== 1'b0) $display("FAIL drop_hidden got %b want 0", bus.dec_inst_valid);
        else n_pass++;
        tick();
        bus.ic_rsp_valid = 1'b0;
        #1;
        n_total++;
        if ({bus.ic_req_valid, bus.ic_req_addr, bus.dec_inst_valid} !== {1'b1, 32'h0000_0400, 1'b0})
            $display("FAIL drop_refetch got %b/%h/%b want 1/00000400/0",
                     bus.ic_req_valid, bus.ic_req_addr, bus.dec_inst_valid);
        else n_pass++;
    endtask

    task automatic test_redirect_same_cycle();
        tick();
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data = 32'h1111_1111;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        #1;
        n_total++;
        if ({bus.dec_clear, bus.dec_inst_valid} !== 2'b10)
            $display("FAIL same_clear got %b want 10", {bus.dec_clear, bus.dec_inst_valid});
        else n_pass++;
        tick();
        bus.ic_rsp_valid = 1'b0;
        #1;
        n_total++;
        if ({bus.ic_req_valid, bus.ic_req_addr, bus.dec_inst_valid} !== {1'b1, 32'h0000_0400, 1'b0})
            $display("FAIL same_refetch got %b/%h/%b want 1/00000400/0",
                     bus.ic_req_valid, bus.ic_req_addr, bus.dec_inst_valid);
        else n_pass++;
    endtask

    task automatic test_be_full_rdy();
        int bad;
        logic [31:0] base_stall;
        logic [31:0] base_fetch;
        base_stall = 32'h0;
        base_fetch = 32'h0;
        bus.dec_next_pc = 32'h0000_0404;
        tick();
        rdy_in = 1'b0;
        repeat (3) tick();
        rdy_in = 1'b1;
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_data = 32'hABCD_0013;
        tick();
        bus.ic_rsp_valid = 1'b0;
        bus.be_full = 1'b1;
`ifdef IF_PERF_CNT_EN
        base_stall = perf_stall_cnt;
        base_fetch = perf_fetch_cnt;
`endif
        #1;
        n_total++;
        if ({bus.dec_inst_valid, bus.dec_inst_addr} !== {1'b0, 32'h0000_0400})
            $display("FAIL full_blocked got %b/%h want 0/00000400", bus.dec_inst_valid, bus.dec_inst_addr);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.dec_inst_valid || bus.ic_req_valid || bus.dec_inst_addr !== 32'h0000_0400) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL full_hold got %0d bad cycles want 0", bad);
        else n_pass++;
        bus.be_full = 1'b0;
        rdy_in = 1'b0;
        #1;
        n_total++;
        if (bus.dec_inst_valid !== 1'b0) $display("FAIL rdy_gates_valid got %b want 0", bus.dec_inst_valid);
        else n_pass++;
        rdy_in = 1'b1;
        #1;
        n_total++;
        if ({bus.dec_inst_valid, bus.dec_inst_addr, bus.dec_inst} !== {1'b1, 32'h0000_0400, 32'hABCD_0013})
            $display("FAIL full_release got %b/%h/%h want 1/00000400/abcd0013",
                     bus.dec_inst_valid, bus.dec_inst_addr, bus.dec_inst);
        else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_total++;
        if (perf_stall_cnt - base_stall !== 32'd5)
            $display("FAIL perf_stall got %0d want 5", perf_stall_cnt - base_stall);
        else n_pass++;
`endif
        tick();
        n_total++;
        if ({bus.ic_req_valid, bus.ic_req_addr, bus.dec_inst_valid} !== {1'b1, 32'h0000_0404, 1'b0})
            $display("FAIL after_release got %b/%h/%b want 1/00000404/0",
                     bus.ic_req_valid, bus.ic_req_addr, bus.dec_inst_valid);
        else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_total++;
        if (perf_fetch_cnt - base_fetch !== 32'd1)
            $display("FAIL perf_fetch got %0d want 1", perf_fetch_cnt - base_fetch);
        else n_pass++;
`endif
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_fetch_seq();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_be_full_rdy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage directly upstream of the decoder.
- Holds the PC and issues one instruction-fetch request at a time to the icache/memory controller.
- Presents each returned word to the decoder with its address, then samples the decoder's combinational next-PC and jalr stall.
- Also handles back-end redirects (mispredict/jalr resolution), including discarding in-flight stale responses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
XLEN, 32, address/instruction width

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; low freezes all state
ic_req_valid  output  1  fetch request valid
ic_req_addr  output  32  fetch address, word aligned
ic_req_ready  input  1  icache accepts request this cycle
ic_rsp_valid  input  1  instruction word returned (one cycle pulse)
ic_rsp_data  input  32  returned instruction
dec_inst  output  32  instruction to decoder
dec_inst_valid  output  1  dec_inst valid this cycle
dec_inst_addr  output  32  address of dec_inst
dec_clear  output  1  flush to decoder, equals redirect_valid
dec_stall  input  1  decoder reports jalr; hold until redirect
dec_next_pc  input  32  decoder-computed next PC
be_full  input  1  downstream cannot accept an instruction
redirect_valid  input  1  back-end redirect
redirect_pc  input  32  redirect target

Behaviour:
- Reset (rst_in low, async): pc=RESET_PC, state=FETCH, inst_reg=0; all outputs 0 except ic_req_addr=RESET_PC.
- rdy_in low: no register updates. dec_inst_valid forced 0. ic_req_valid is held at its registered value; the icache must not complete a handshake while rdy_in is low.
- States:
  - FETCH: ic_req_valid=1, ic_req_addr=pc. Request accepted when ic_req_ready is high; go to WAIT.
  - WAIT: on ic_rsp_valid, inst_reg<=ic_rsp_data; go to ISSUE.
  - ISSUE: dec_inst=inst_reg, dec_inst_addr=pc, dec_inst_valid = !be_full. If be_full, stay in ISSUE. When valid:
    - dec_stall=1: go to HOLD, pc unchanged.
    - otherwise: pc<=dec_next_pc, go to FETCH.
  - HOLD: no requests, dec_inst_valid=0; wait for redirect.
  - DROP: wait for ic_rsp_valid, discard the data, go to FETCH.
- Redirect has the highest priority in every state:
  - pc<=redirect_pc with bits[1:0] cleared; dec_clear=1 the same cycle; dec_inst_valid forced 0.
  - Next state is DROP if a request is outstanding afterwards: WAIT without ic_rsp_valid this cycle, or FETCH with ic_req_ready this cycle. Otherwise FETCH.
  - Response and redirect in the same WAIT cycle: response discarded, go to FETCH.
- Exactly one outstanding request; ic_req_valid never asserted in WAIT/DROP/ISSUE/HOLD.
- Throughput with a 1-cycle icache: request t, response t+1, issue t+2, next request t+3.
- dec_next_pc is sampled only on ISSUE-with-valid; the lower 2 bits are cleared on load.
- PC arithmetic wraps modulo 2^32.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined: adds outputs perf_fetch_cnt[31:0], counting accepted ISSUE cycles, and perf_stall_cnt[31:0], counting cycles in HOLD or ISSUE with be_full.
  - Both reset to 0 and wrap at 2^32.
  - Both freeze with rdy_in low.
- When undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package if_pkg: XLEN, RESET_PC default, state encoding (FETCH, WAIT, ISSUE, HOLD, DROP as 3-bit constants).
- Sub-module if_perf_cnt holds both counters, instantiated only under IF_PERF_CNT_EN. All other logic stays in inst_fetcher.

Test Plan:
- Reset then 1-cycle icache returning 32'h00000013 (addi): requests at 0x0, 0x4, 0x8 spaced 3 cycles apart; dec_inst_addr follows.
- Decoder returns dec_next_pc=0x100 for a jal at 0x8 -> next ic_req_addr=0x100.
- dec_stall=1 at 0x10 -> HOLD, no requests for 20 cycles; redirect_pc=0x203 -> dec_clear pulse, next ic_req_addr=0x200.
- Redirect to 0x400 while in WAIT, response arriving 2 cycles later with 0xDEADBEEF -> never shown on dec_inst; next request is 0x400.
- Redirect in the same cycle as ic_rsp_valid -> data dropped, request 0x400 issued the next cycle (no DROP).
- be_full held 5 cycles in ISSUE, and rdy_in low 3 cycles mid-WAIT -> instruction presented once after release, PC unchanged meanwhile; with IF_PERF_CNT_EN, perf_stall_cnt=5.
